aes_link_host: RTL and testbench
================================

Name: aes_link_host

Overview:
- Platform-side initiator for the 9-bit strobed byte link into the AES chip.
- Serializes a 128-bit key and a 128-bit plaintext as 32 bytes on aes_tx[7:0], each byte qualified by the strobe aes_tx[8].
- Collects the 16 ciphertext bytes the chip returns on aes_rx[7:0], qualified by aes_rx[8], and presents them as one 128-bit result.
- Runs in the platform clock domain; aes_rx is asynchronous to clk because it originates in the chip clock domain.

Parameters:
- CLK_FREQ, 50_000_000: platform clock frequency in Hz.
- TX_FREQ, 50_000: byte rate on aes_tx in Hz. DIV = CLK_FREQ/TX_FREQ clocks per byte. DIV must be an even number ≥ 4.
- TIMEOUT_CYCLES, 5_000_000: maximum number of clocks to wait for any RX byte before aborting.

Ports:
- clk  in  1  platform clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a transaction; only accepted in IDLE.
- key  in  128  cipher key, sampled when start is accepted.
- text  in  128  plaintext, sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse when all 16 RX bytes have been captured.
- timeout  out  1  one-cycle pulse when a transaction is aborted by the timeout.
- result  out  128  last complete ciphertext.
- aes_tx  out  9  [7:0] byte to the chip, [8] byte strobe (shi).
- aes_rx  in  9  [7:0] byte from the chip, [8] byte strobe (sho).

Behaviour:
- Reset values: busy=0, done=0, timeout=0, result=0, aes_tx=9'h000. The FSM goes to IDLE and all counters clear. Reset asserted mid-transaction aborts immediately with no pulses.
- FSM states: IDLE, SEND, WAIT_RX, FINISH.
- IDLE:
  - start=1 latches {key,text} into a 256-bit shift register and moves to SEND.
  - start while not in IDLE is ignored.
- SEND:
  - Per byte slot, a divider counts 0..DIV-1.
  - aes_tx[7:0] holds the current byte for the whole slot.
  - aes_tx[8]=1 for counts 0..DIV/2-1 and 0 for the rest of the slot.
  - Byte order: key[127:120] first, through key[7:0], then text[127:120] through text[7:0].
  - After slot 31 completes, aes_tx returns to 0 and the FSM moves to WAIT_RX.
  - First strobe rises 1 cycle after start is accepted.
  - Total SEND duration is exactly 32*DIV cycles.
- RX path:
  - aes_rx[8] passes through a 2-flop synchronizer.
  - aes_rx[7:0] is registered in parallel, delayed to match the strobe.
  - A rising edge of the synchronized strobe captures the aligned byte.
  - The chip guarantees data stable while its strobe is high.
- WAIT_RX:
  - Each captured byte shifts into the result accumulator MSB-first: the first byte lands in bits [127:120].
  - A 4-bit byte counter tracks captured bytes.
  - On the 16th byte: result is updated with the accumulator the next cycle, done pulses in that same cycle, and the FSM goes FINISH → IDLE (busy drops with done).
- Timeout:
  - The timeout counter clears on entry to WAIT_RX and on every captured byte.
  - If it reaches TIMEOUT_CYCLES: timeout pulses for 1 cycle, result is NOT updated, the FSM goes to IDLE, and the partial accumulator is discarded.
- Strobe edges detected in IDLE or SEND are ignored and are not counted.
- A strobe edge in the same cycle as a timeout expiry: timeout wins and the byte is dropped.
- done and timeout are never high together.

Optional Feature:
- Macro AES_LINK_EXPECT_EN.
- When defined, the block adds:
  - input expect[127:0], sampled with key/text on start.
  - outputs total[31:0] and correct[31:0], reset to 0.
- total increments on every done or timeout pulse.
- correct increments on done when the new result equals the latched expect.
- Both counters saturate at 32'hFFFF_FFFF.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset, then idle for 100 cycles → aes_tx=0, busy=0, result=0, no done or timeout pulse.
- Run with DIV=4 (CLK_FREQ=200, TX_FREQ=50), key=000102..0f, text=00112233..ff:
  - 32 strobes are seen on aes_tx, each 2 cycles high and 2 cycles low.
  - The bytes appear in the order 00,01,..,0f,00,11,..,ff.
  - SEND lasts exactly 128 cycles.
- The chip model returns 69c4e0d86a7b0430d8cdb78070b4c55a with an async strobe period of 7 clocks → result=69c4..5a, one done pulse, busy low in the done cycle.
- TIMEOUT_CYCLES=50 and the chip returns only 5 bytes → timeout pulses 50 cycles after the 5th byte, result keeps its previous value, the FSM is back in IDLE, and a new start is accepted.
- start pulsed again mid-SEND and a spurious aes_rx[8] pulse injected during SEND → neither affects the byte stream or the RX count.
- With AES_LINK_EXPECT_EN: run 3 transactions with the correct expect, 1 with a wrong expect, and 1 that times out → total=5, correct=3.

Source files
------------

// File: rtl/aes_link_host.sv
// aes_link_host: sends key/text over the strobed byte link and collects the 16-byte ciphertext.
// Define AES_LINK_EXPECT_EN to add the expected-value port and the total/correct counters.
module aes_link_host #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TX_FREQ        = 50_000,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] text,
`ifdef AES_LINK_EXPECT_EN
  input  logic [127:0] expected,
  output logic [31:0]  total,
  output logic [31:0]  correct,
`endif
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [127:0] result,
  output logic [8:0]   aes_tx,
  input  logic [8:0]   aes_rx
);
  localparam int DIV = CLK_FREQ / TX_FREQ;
  localparam int CW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, FINISH} state_t;
  state_t         r_state, w_next;
  logic [255:0]   r_sr;
  logic [CW-1:0]  r_div;
  logic [4:0]     r_slot;
  logic [127:0]   r_acc, r_result;
  logic [3:0]     r_bcnt;
  logic [31:0]    r_tcnt;
  logic [2:0]     r_sync;
  logic [7:0]     r_d1, r_d2;
  logic           r_done, r_timeout;
  logic           w_edge, w_slot_end, w_expire, w_last;
  // r_d2 lines up with r_sync[1], so the byte is taken with the synchronized strobe edge
  assign w_edge     = r_sync[1] & ~r_sync[2];
  assign w_slot_end = r_div == CW'(DIV - 1);
  assign w_expire   = r_state == WAIT_RX && r_tcnt + 32'd1 == 32'(TIMEOUT_CYCLES);
  assign w_last     = r_state == WAIT_RX && w_edge && !w_expire && r_bcnt == 4'd15;
  assign busy       = r_state != IDLE;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign result     = r_result;
  assign aes_tx     = r_state == SEND ? {r_div < CW'(DIV / 2), r_sr[255:248]} : 9'h000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SEND : IDLE;
      SEND:    w_next = w_slot_end && r_slot == 5'd31 ? WAIT_RX : SEND;
      WAIT_RX: w_next = w_expire ? IDLE : w_last ? FINISH : WAIT_RX;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sr      <= '0;
      r_div     <= '0;
      r_slot    <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_bcnt    <= '0;
      r_tcnt    <= '0;
      r_sync    <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync    <= {r_sync[1:0], aes_rx[8]};
      r_d1      <= aes_rx[7:0];
      r_d2      <= r_d1;
      r_done    <= r_state == FINISH;
      r_timeout <= w_expire;
      if (r_state == FINISH) r_result <= r_acc;
      if (r_state == IDLE) begin
        r_div  <= '0;
        r_slot <= '0;
        r_bcnt <= '0;
        r_tcnt <= '0;
        r_acc  <= '0;
        if (start) r_sr <= {key, text};
      end else if (r_state == SEND) begin
        r_div <= w_slot_end ? '0 : r_div + CW'(1);
        if (w_slot_end) begin
          r_slot <= r_slot + 5'd1;
          r_sr   <= {r_sr[247:0], 8'h00};
        end
      end else if (r_state == WAIT_RX) begin
        r_tcnt <= w_edge ? '0 : r_tcnt + 32'd1;
        // an expiring timeout takes priority over a byte arriving in the same cycle
        if (w_edge && !w_expire) begin
          r_acc  <= {r_acc[119:0], r_d2};
          r_bcnt <= r_bcnt + 4'd1;
        end
      end
    end
`ifdef AES_LINK_EXPECT_EN
  logic [127:0] r_exp;
  logic [31:0]  r_total, r_correct;
  assign total   = r_total;
  assign correct = r_correct;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_exp     <= '0;
      r_total   <= '0;
      r_correct <= '0;
    end else begin
      if (r_state == IDLE && start) r_exp <= expected;
      if ((r_state == FINISH || w_expire) && r_total != 32'hFFFF_FFFF) r_total <= r_total + 32'd1;
      if (r_state == FINISH && r_acc == r_exp && r_correct != 32'hFFFF_FFFF) r_correct <= r_correct + 32'd1;
    end
`endif
endmodule

// File: tb/tb_aes_link_host.sv
// tb_aes_link_host: randomized link transactions checked against a byte-level model of the link.
module tb_aes_link_host;
  localparam int DIV = 4;
  localparam int TO  = 50;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] key = '0, text = '0;
  logic         busy, done, timeout;
  logic [127:0] result;
  logic [8:0]   aes_tx;
  logic [8:0]   aes_rx = '0;
`ifdef AES_LINK_EXPECT_EN
  logic [127:0] exp_in = '0;
  logic [31:0]  total, correct;
`endif
  int           checks = 0, errors = 0;
  int           cyc = 0, n_done = 0, n_to = 0, n_both = 0, to_cyc = 0;
  logic         done_busy = 1'b0;
  logic [127:0] exp_result = '0;
  int           exp_total = 0, exp_correct = 0;

  aes_link_host #(.CLK_FREQ(200), .TX_FREQ(50), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .text(text),
`ifdef AES_LINK_EXPECT_EN
    .expected(exp_in), .total(total), .correct(correct),
`endif
    .busy(busy), .done(done), .timeout(timeout), .result(result),
    .aes_tx(aes_tx), .aes_rx(aes_rx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      n_done++;
      done_busy = busy;
    end
    if (timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if (done && timeout) n_both++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run_txn(input logic [127:0] k, input logic [127:0] t, input logic [127:0] ct,
                         input int nret, input bit good_exp);
    logic [255:0] kt;
    logic [8:0]   exp9;
    int           bad, d0, t0, noise_at, rise, gap;
    kt = {k, t};
    @(negedge clk);
    #1;
    d0 = n_done;
    t0 = n_to;
    key = k;
    text = t;
`ifdef AES_LINK_EXPECT_EN
    exp_in = good_exp ? ct : ~ct;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1);
    bad = 0;
    noise_at = $urandom_range(2, 27) * DIV + 1;
    for (int i = 0; i < 32 * DIV; i++) begin
      exp9 = {((i % DIV) < DIV / 2), kt[255 - 8 * (i / DIV) -: 8]};
      if (aes_tx !== exp9) bad++;
      if (i == noise_at) begin
        start = 1'b1;
        key = ~k;
        aes_rx = {1'b1, 8'($urandom())};
      end else begin
        start = 1'b0;
        aes_rx[8] = 1'b0;
      end
      @(negedge clk);
    end
    chk("tx_stream", bad, 0);
    chk("tx_idle", aes_tx, 0);
    chk("busy_wait", busy, 1);
    gap = $urandom_range(2, 15);
    repeat (gap) @(negedge clk);
    rise = 0;
    for (int j = 0; j < nret; j++) begin
      #2 aes_rx = {1'b1, ct[127 - 8 * j -: 8]};
      rise = cyc;
      repeat (3) @(negedge clk);
      #2 aes_rx[8] = 1'b0;
      repeat (4) @(negedge clk);
    end
    #1;
    for (int w = 0; w < 200 && n_done == d0 && n_to == t0; w++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    if (nret == 16) begin
      exp_result = ct;
      exp_total++;
      if (good_exp) exp_correct++;
      chk("done_cnt", n_done - d0, 1);
      chk("to_cnt", n_to - t0, 0);
      chk("busy_at_done", done_busy, 0);
    end else begin
      exp_total++;
      chk("to_cnt", n_to - t0, 1);
      chk("done_cnt", n_done - d0, 0);
      chk("to_time", to_cyc, rise + TO + 3);
    end
    chk("result", result, exp_result);
    chk("busy_end", busy, 0);
`ifdef AES_LINK_EXPECT_EN
    chk("total", total, exp_total);
    chk("correct", correct, exp_correct);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, d0, t0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    d0 = n_done;
    t0 = n_to;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (aes_tx !== 9'h000 || busy !== 1'b0) bad++;
    end
    #1;
    chk("idle_bad_cycles", bad, 0);
    chk("idle_result", result, 0);
    chk("idle_pulses", (n_done - d0) + (n_to - t0), 0);
`ifdef AES_LINK_EXPECT_EN
    chk("idle_total", total, 0);
`endif
    run_txn(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16, 1'b1);
    for (int n = 0; n < 3; n++) run_txn(rnd128(), rnd128(), rnd128(), 16, n != 1);
    run_txn(rnd128(), rnd128(), rnd128(), 5, 1'b1);
    run_txn(rnd128(), rnd128(), rnd128(), 16, 1'b1);
    @(negedge clk);
    key = rnd128();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    d0 = n_done;
    t0 = n_to;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx", aes_tx, 0);
    chk("rst_result", result, 0);
    exp_result = '0;
    exp_total = 0;
    exp_correct = 0;
`ifdef AES_LINK_EXPECT_EN
    chk("rst_total", total, 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("rst_no_pulse", (n_done - d0) + (n_to - t0), 0);
    run_txn(rnd128(), rnd128(), rnd128(), 16, 1'b1);
    chk("both_pulses", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
